// File: rtl/pio_tx_fifo.sv
// PIO transmit FIFO: first-word fall-through queue between the bus TXF write
// path and the state machine's output shift register, with FJOIN_TX depth doubling.
module pio_tx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fjoin_tx,
   input  logic                      push,
   input  logic [WIDTH-1:0]          din,
   input  logic                      pop,
   output logic [WIDTH-1:0]          dout,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(2*DEPTH):0]  level,
   output logic                      overflow,
   output logic                      underflow,
   input  logic [1:0]                flag_clr
);

   localparam int CAP_JOINED = 2 * DEPTH;
   localparam int PW         = $clog2(CAP_JOINED);
   localparam int LW         = PW + 1;

   logic [WIDTH-1:0] mem [CAP_JOINED];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             fjoin_q;
   logic [LW-1:0]    cap;
   logic             join_chg;
   logic             push_ok;
   logic             pop_ok;
   logic             ovf_set;
   logic             udf_set;

   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [LW-1:0] c);
      return ({1'b0, p} == c - LW'(1)) ? '0 : p + PW'(1);
   endfunction

   // A join change flushes the queue, so push/pop are masked and raise no flags.
   always_comb begin
      cap      = fjoin_q ? LW'(CAP_JOINED) : LW'(DEPTH);
      empty    = (level == '0);
      full     = (level == cap);
      join_chg = (fjoin_tx != fjoin_q);
      push_ok  = push && (!full || pop) && !join_chg;
      pop_ok   = pop && !empty && !join_chg;
      ovf_set  = push && full && !pop && !join_chg;
      udf_set  = pop && empty && !join_chg;
      dout     = empty ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         fjoin_q   <= fjoin_tx;
      end else begin
         fjoin_q <= fjoin_tx;

         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (flag_clr[0]) begin
            overflow <= 1'b0;
         end
         if (udf_set) begin
            underflow <= 1'b1;
         end else if (flag_clr[1]) begin
            underflow <= 1'b0;
         end

         if (join_chg) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr <= adv(wr_ptr, cap);
            end
            if (pop_ok) begin
               rd_ptr <= adv(rd_ptr, cap);
            end
            if (push_ok && !pop_ok) begin
               level <= level + LW'(1);
            end else if (pop_ok && !push_ok) begin
               level <= level - LW'(1);
            end
         end
      end
   end

endmodule

// File: doc/pio_tx_fifo.md
Name: pio_tx_fifo

Overview:
Transmit FIFO for one PIO state machine. It sits between the system-bus TXF write path and the state machine's output shift register, and supplies the 32-bit word loaded on PULL or autopull. It supports the FJOIN_TX option, which doubles the depth, and reports level, full/empty and sticky over/underflow flags to the FDEBUG/FSTAT registers.

Parameters:
WIDTH, 32, data word width in bits.
DEPTH, 4, entries in normal mode; must be a power of two and at least 2. Joined mode gives 2*DEPTH entries.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
join  input  1  1 = joined mode (2*DEPTH entries); 0 = normal mode (DEPTH entries).
push  input  1  bus write strobe.
din  input  WIDTH  bus write data.
pop  input  1  state-machine pull strobe (PULL or autopull).
dout  output  WIDTH  head-of-queue word; first-word fall-through.
empty  output  1  level == 0.
full  output  1  level == current capacity.
level  output  $clog2(2*DEPTH)+1  number of valid entries.
overflow  output  1  sticky flag: push attempted while full.
underflow  output  1  sticky flag: pop attempted while empty.
flag_clr  input  2  write-1-to-clear; bit0 clears overflow, bit1 clears underflow.

Behaviour:
- Storage: 2*DEPTH x WIDTH registers. Normal mode uses only entries 0..DEPTH-1.
- Pointers: rd_ptr and wr_ptr are $clog2(2*DEPTH) bits wide. They wrap modulo the current capacity (DEPTH or 2*DEPTH).
- level is a registered counter, not derived from the pointers.
- Reset: rd_ptr=0, wr_ptr=0, level=0, overflow=0, underflow=0, join_q=join. Outputs after reset: empty=1, full=0, dout=0.
- dout = mem[rd_ptr] when level != 0; otherwise dout = 0. Combinational from registered state, so zero-latency read.
- Pushed data is visible on dout on the cycle after the push edge.
- full and empty are evaluated from state at the start of the cycle (pre-edge).
- Push accept: push && (!full || pop). Write din to mem[wr_ptr], then advance wr_ptr.
- Push rejected: push && full && !pop. No state change except overflow <= 1.
- Pop accept: pop && !empty. Advance rd_ptr. dout shows the next entry on the following cycle.
- Pop rejected: pop && empty. No pointer change; underflow <= 1. There is no bypass: a push in the same cycle is still accepted, giving level=1.
- Simultaneous push and pop when full: both accepted, level unchanged, pointers both advance.
- Simultaneous push and pop in the partial range: both accepted, level unchanged.
- level update: +1 on push-only accept, -1 on pop-only accept, otherwise unchanged. level never exceeds capacity.
- Flags: set condition has priority over flag_clr in the same cycle. Otherwise the corresponding flag_clr bit clears the flag.
- Join change: join is registered as join_q. On any cycle where join != join_q:
  - the FIFO flushes (rd_ptr=wr_ptr=level=0);
  - push and pop in that cycle are ignored and do not set flags;
  - flags are retained;
  - capacity follows the new join from the next cycle.
- Reset asserted mid-operation: all contents are discarded, regardless of push/pop that cycle.

Test Plan:
- Reset, then 4 pushes 0xA0..0xA3 with join=0 -> full=1, level=4, dout=0xA0; 4 pops return 0xA0..0xA3 in order; then empty=1, dout=0.
- join=0, FIFO full, 5th push 0xFF with no pop -> overflow=1, level=4, contents unchanged; flag_clr=01 -> overflow=0 next cycle.
- Empty FIFO, push 0x11 and pop in the same cycle -> underflow=1, level=1, dout=0x11.
- Full FIFO (join=0), push 0x55 and pop in the same cycle -> level=4, old head removed, 0x55 read as the 4th pop afterward.
- join=1, push 8 words 0..7 -> full=1 only after the 8th push; 20 mixed push/pop cycles -> strict order maintained, pointer wrap at 8 verified.
- Level=3, toggle join 0->1 with push asserted -> level=0, empty=1, no overflow set; next push is accepted normally.
